// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the burst-granular FIFO arbiter.
package fifo_arb_pkg;

    // Arbiter phases: waiting for admission, streaming a burst from one
    // requester, and one dead cycle while the FIFO count catches up.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST0 = 2'd1,
        ST_BURST1 = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    // True when a whole burst is guaranteed to fit behind the current
    // occupancy. An occupancy above the capacity is treated as full.
    function automatic logic fits(input logic [31:0] count,
                                  input logic [31:0] burst,
                                  input logic [31:0] depth);
        return (count <= depth) && ((count + burst) <= depth);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: on a tie the requester that was not
// granted last wins; otherwise the single active requester is chosen.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       choice
);

    // Pure combinational pick; choice is only meaningful when valid is high.
    always_comb begin
        valid  = |req;
        choice = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Shares one downstream FIFO between two AXI-Stream producers, admitting
// fixed-length bursts only when the FIFO occupancy guarantees room for
// the whole burst, so a granted burst never stalls on FIFO fullness.
//
// Handshake: a beat transfers on a rising edge where TVALID and TREADY
// are both high. TVALID never depends on TREADY; the granted requester's
// TREADY is a combinational copy of out_V_TREADY, and the data path is a
// zero-latency pass-through of the granted stream.
module fifo_burst_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 784,
    parameter int CNT_W = 10,
    parameter int BURST = 16,
    localparam int BCW  = $clog2(BURST + 1)
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [WIDTH-1:0] in0_V_TDATA,
    input  logic             in0_V_TVALID,
    output logic             in0_V_TREADY,
    input  logic [WIDTH-1:0] in1_V_TDATA,
    input  logic             in1_V_TVALID,
    output logic             in1_V_TREADY,
    output logic [WIDTH-1:0] out_V_TDATA,
    output logic             out_V_TVALID,
    input  logic             out_V_TREADY,
    input  logic [CNT_W-1:0] fifo_count,
    output logic [1:0]       grant,
    output logic             busy,
    output state_t           dbg_state,
    output logic [BCW-1:0]   dbg_beat_cnt
);

    state_t         state;
    state_t         next_state;
    logic [BCW-1:0] beat_cnt;
    logic           last;
    logic           pick_valid;
    logic           pick_choice;
    logic           fits_now;
    logic           hs;
    logic           take;

    assign fits_now = fits(32'(fifo_count), 32'(BURST), 32'(DEPTH));
    assign hs       = out_V_TVALID & out_V_TREADY;
    assign take     = (state == ST_IDLE) && pick_valid && fits_now;

    rr_pick2 u_pick (
        .req    ({in1_V_TVALID, in0_V_TVALID}),
        .last   (last),
        .valid  (pick_valid),
        .choice (pick_choice)
    );

    // Next-state logic and the stream mux; idle/settle block both sources.
    always_comb begin
        next_state   = state;
        out_V_TDATA  = in0_V_TDATA;
        out_V_TVALID = 1'b0;
        in0_V_TREADY = 1'b0;
        in1_V_TREADY = 1'b0;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    next_state = pick_choice ? ST_BURST1 : ST_BURST0;
                end
            end
            ST_BURST0: begin
                out_V_TDATA  = in0_V_TDATA;
                out_V_TVALID = in0_V_TVALID;
                in0_V_TREADY = out_V_TREADY;
                if (hs && (beat_cnt == BCW'(BURST - 1))) begin
                    next_state = ST_SETTLE;
                end
            end
            ST_BURST1: begin
                out_V_TDATA  = in1_V_TDATA;
                out_V_TVALID = in1_V_TVALID;
                in1_V_TREADY = out_V_TREADY;
                if (hs && (beat_cnt == BCW'(BURST - 1))) begin
                    next_state = ST_SETTLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register with grant/busy registered as decodes of the new state.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_IDLE;
            grant <= 2'b00;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            grant <= {next_state == ST_BURST1, next_state == ST_BURST0};
            busy  <= (next_state == ST_BURST0) || (next_state == ST_BURST1);
        end
    end

    // Beat counter restarts on each grant; last records who was granted.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            beat_cnt <= '0;
            last     <= 1'b1;
        end else if (take) begin
            beat_cnt <= '0;
            last     <= pick_choice;
        end else if (hs) begin
            beat_cnt <= beat_cnt + BCW'(1);
        end
    end

    assign dbg_state    = state;
    assign dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Randomized bench for fifo_burst_arbiter with a transaction-level model:
// the model tracks who owns the FIFO, how many beats of the burst remain
// and the per-source sequence numbers the output must carry.
module tb_fifo_burst_arbiter;
    import fifo_arb_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 784;
    localparam int CNT_W = 10;
    localparam int BURST = 16;
    localparam int BCW   = 5;

    typedef logic [BCW+2+1+1+1+1+WIDTH-1:0] vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in0_d, in1_d, out_d;
    logic             in0_v, in0_r, in1_v, in1_r, out_v;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] fifo_count = '0;
    logic [1:0]       grant;
    logic             busy;
    state_t           dbg_state;
    logic [BCW-1:0]   dbg_beat;

    // stimulus state
    logic [1:0]  iv = 2'b00;
    logic [14:0] d_seq [2];
    logic [1:0]  last_in_hs = 2'b00;
    int          pv [2];
    int          prdy = 100;
    logic [CNT_W-1:0] cnt_fixed = '0;
    bit          cnt_rand = 1'b0;

    // reference model: owner -1 idle, 0/1 bursting, 2 settling
    int          m_owner = -1;
    int          m_last = 1;
    int          m_beats = 0;
    logic [14:0] m_seq [2];

    // scoreboard and results of the most recent step
    logic [WIDTH-1:0] exp_q[$];
    vec_t             obs_vec, exp_vec;
    logic [1:0]       obs_grant;
    bit               sb_hs, sb_empty;
    logic [WIDTH-1:0] sb_got, sb_exp;

    int tests_run = 0;
    int tests_failed = 0;

    assign in0_v = iv[0];
    assign in1_v = iv[1];
    assign in0_d = {1'b0, d_seq[0]};
    assign in1_d = {1'b1, d_seq[1]};

    fifo_burst_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .BURST(BURST)
    ) dut (
        .ap_clk       (clk),
        .ap_rst_n     (rst_n),
        .in0_V_TDATA  (in0_d),
        .in0_V_TVALID (in0_v),
        .in0_V_TREADY (in0_r),
        .in1_V_TDATA  (in1_d),
        .in1_V_TVALID (in1_v),
        .in1_V_TREADY (in1_r),
        .out_V_TDATA  (out_d),
        .out_V_TVALID (out_v),
        .out_V_TREADY (out_ready),
        .fifo_count   (fifo_count),
        .grant        (grant),
        .busy         (busy),
        .dbg_state    (dbg_state),
        .dbg_beat_cnt (dbg_beat)
    );

    // clock
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_beats = 0;
        exp_q.delete();
    endtask

    // New random inputs; a source holding valid without a transfer keeps it.
    task automatic drive_inputs();
        for (int k = 0; k < 2; k++) begin
            if (!(iv[k] && !last_in_hs[k])) begin
                iv[k] = (int'($urandom_range(99, 0)) < pv[k]);
            end
        end
        out_ready  = (int'($urandom_range(99, 0)) < prdy);
        fifo_count = cnt_rand ? CNT_W'($urandom_range(1023, 740)) : cnt_fixed;
    endtask

    // One clock: observe at negedge, compute expectations, advance at posedge.
    task automatic step();
        logic [1:0]       eg;
        logic             eb, ev;
        logic [1:0]       er;
        logic [WIDTH-1:0] ed;
        logic             m_hs, fits_m;
        logic [1:0]       in_hs;
        int               k;
        @(negedge clk);
        obs_grant = grant;
        obs_vec = {dbg_beat, grant, busy, in1_r, in0_r, out_v, (out_v ? out_d : 16'h0)};
        eg = 2'b00; eb = 1'b0; er = 2'b00; ev = 1'b0; ed = '0;
        if (m_owner == 0 || m_owner == 1) begin
            eg = (m_owner == 0) ? 2'b01 : 2'b10;
            eb = 1'b1;
            er[m_owner] = out_ready;
            ev = iv[m_owner];
            ed = ev ? {(m_owner == 1), m_seq[m_owner]} : 16'h0;
        end
        exp_vec = {BCW'(m_beats), eg, eb, er[1], er[0], ev, ed};
        m_hs = ev && out_ready;
        if (m_hs) exp_q.push_back(ed);
        sb_hs = out_v && out_ready;
        sb_empty = 1'b0;
        sb_got = out_d;
        sb_exp = '0;
        if (sb_hs) begin
            if (exp_q.size() == 0) sb_empty = 1'b1;
            else sb_exp = exp_q.pop_front();
        end
        in_hs  = iv & {in1_r, in0_r};
        fits_m = (int'(fifo_count) <= DEPTH) && (int'(fifo_count) + BURST <= DEPTH);
        @(posedge clk);
        if (m_owner == -1) begin
            if (fits_m && iv != 2'b00) begin
                k = (iv == 2'b11) ? (1 - m_last) : (iv[1] ? 1 : 0);
                m_owner = k;
                m_last  = k;
                m_beats = 0;
            end
        end else if (m_owner == 2) begin
            m_owner = -1;
        end else if (m_hs) begin
            m_beats++;
            m_seq[m_owner] = m_seq[m_owner] + 15'd1;
            if (m_beats == BURST) m_owner = 2;
        end
        for (int j = 0; j < 2; j++) if (in_hs[j]) d_seq[j] = d_seq[j] + 15'd1;
        last_in_hs = in_hs;
        #1;
        drive_inputs();
    endtask

    task automatic test_reset();
        iv = 2'b11;
        out_ready = 1'b1;
        fifo_count = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({dbg_beat, grant, busy, in1_r, in0_r, out_v} !== 11'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got beat=%0d grant=%b busy=%b rdy=%b%b ov=%b, expected all zero",
                     dbg_beat, grant, busy, in1_r, in0_r, out_v);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        pv[0] = 100; pv[1] = 0; prdy = 100; cnt_fixed = '0; cnt_rand = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL single cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (sb_hs) begin
                tests_run++;
                if (sb_empty || sb_got !== sb_exp) begin
                    tests_failed++;
                    $display("FAIL single_data cyc %0d: got %h expected %h (empty=%0d)", i, sb_got, sb_exp, sb_empty);
                end
            end
        end
    endtask

    task automatic test_alternate();
        int bursts[$];
        logic [1:0] prev_g;
        pv[0] = 100; pv[1] = 100; prdy = 100; cnt_fixed = '0; cnt_rand = 1'b0;
        prev_g = 2'b00;
        for (int i = 0; i < 90; i++) begin
            step();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL alternate cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (sb_hs) begin
                tests_run++;
                if (sb_empty || sb_got !== sb_exp) begin
                    tests_failed++;
                    $display("FAIL alternate_data cyc %0d: got %h expected %h (empty=%0d)", i, sb_got, sb_exp, sb_empty);
                end
            end
            if (obs_grant != 2'b00 && prev_g == 2'b00) bursts.push_back(obs_grant[1] ? 1 : 0);
            prev_g = obs_grant;
        end
        for (int b = 1; b < bursts.size(); b++) begin
            tests_run++;
            if (bursts[b] == bursts[b-1]) begin
                tests_failed++;
                $display("FAIL alternate_order burst %0d: got requester %0d twice, expected alternation", b, bursts[b]);
            end
        end
    endtask

    task automatic test_admission();
        logic [CNT_W-1:0] vals [4];
        vals[0] = 10'd768; vals[1] = 10'd769; vals[2] = 10'd784; vals[3] = 10'd1000;
        pv[0] = 100; pv[1] = 100; prdy = 100; cnt_rand = 1'b0;
        for (int v = 0; v < 4; v++) begin
            cnt_fixed = vals[v];
            for (int i = 0; i < 40; i++) begin
                step();
                tests_run++;
                if (obs_vec !== exp_vec) begin
                    tests_failed++;
                    $display("FAIL admission cnt=%0d cyc %0d: got %h expected %h", vals[v], i, obs_vec, exp_vec);
                end
                if (vals[v] != 10'd768 && i >= 22) begin
                    tests_run++;
                    if (obs_grant !== 2'b00 || in0_r !== 1'b0 || in1_r !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL admission_block cnt=%0d cyc %0d: got grant=%b rdy=%b%b expected 00/00",
                                 vals[v], i, obs_grant, in1_r, in0_r);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        pv[0] = 100; pv[1] = 60; prdy = 50; cnt_fixed = '0; cnt_rand = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (i == 250) cnt_rand = 1'b1;
            step();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL backpressure cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (sb_hs) begin
                tests_run++;
                if (sb_empty || sb_got !== sb_exp) begin
                    tests_failed++;
                    $display("FAIL backpressure_data cyc %0d: got %h expected %h (empty=%0d)", i, sb_got, sb_exp, sb_empty);
                end
            end
        end
        cnt_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  seen;
        pv[0] = 100; pv[1] = 100; prdy = 100; cnt_fixed = '0; cnt_rand = 1'b0;
        n = 0;
        while (!((m_owner == 0 || m_owner == 1) && m_beats == 5) && n < 200) begin
            step();
            n++;
        end
        tests_run++;
        if (n >= 200) begin
            tests_failed++;
            $display("FAIL reset_mid_reach: got no burst at beat 5 within 200 cycles, expected one");
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({dbg_beat, grant, busy, in1_r, in0_r, out_v} !== 11'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got beat=%0d grant=%b busy=%b rdy=%b%b ov=%b, expected all zero",
                     dbg_beat, grant, busy, in1_r, in0_r, out_v);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL reset_mid cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (sb_hs) begin
                tests_run++;
                if (sb_empty || sb_got !== sb_exp) begin
                    tests_failed++;
                    $display("FAIL reset_mid_data cyc %0d: got %h expected %h (empty=%0d)", i, sb_got, sb_exp, sb_empty);
                end
            end
            if (!seen && obs_grant != 2'b00) begin
                seen = 1'b1;
                tests_run++;
                if (obs_grant !== 2'b01) begin
                    tests_failed++;
                    $display("FAIL reset_mid_first_grant: got %b expected 01", obs_grant);
                end
            end
        end
    endtask

    initial begin
        d_seq[0] = '0; d_seq[1] = '0;
        m_seq[0] = '0; m_seq[1] = '0;
        pv[0] = 0; pv[1] = 0;
        test_reset();
        test_single();
        test_alternate();
        test_admission();
        test_backpressure();
        test_reset_mid();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL leftover_beats: got %0d unmatched expected beats, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
